// File: rtl/lab_3_pkg.sv
// lab_3_pkg
// Shared types and helpers for the slide-switch input conditioner.
//   db_state_t     : per-bit debounce FSM state
//   NUM_SW         : number of switch bits feeding the a/b/c logic block
//   db_count_width : width of a debounce counter that must reach DEBOUNCE_CYCLES
package lab_3_pkg;

    typedef enum logic {
        STABLE,
        COUNTING
    } db_state_t;

    localparam int NUM_SW = 3;

    // The counter never exceeds DEBOUNCE_CYCLES-1, but the extra headroom
    // of $clog2(n+1) keeps the width at least 1 bit when n is 1.
    function automatic int db_count_width(input int debounce_cycles);
        return $clog2(debounce_cycles + 1);
    endfunction

endpackage : lab_3_pkg

// File: rtl/lab_3_input_conditioner_debounce_bit.sv
// debounce_bit
// One switch bit: SYNC_STAGES-deep synchroniser followed by a debounce FSM.
// Ports:
//   clk    : system clock, all state on the rising edge
//   rst_n  : asynchronous active-low reset, clears synchroniser, FSM, counter, level
//   sw     : raw asynchronous switch level
//   level  : registered debounced level
//   update : high in the cycle before the edge on which level flips; it is a
//            function of registered state only, so the parent can register it
//            into a strobe that lines up exactly with the new level.
module debounce_bit
    import lab_3_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw,
    output logic level,
    output logic update
);

    localparam int CNT_W = db_count_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] FIRST_COUNT = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   sync_s;

    db_state_t        state;
    db_state_t        state_nxt;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic             level_nxt;

    // Synchroniser stage: bit 0 samples the raw pin, the last bit is the
    // metastability-settled copy used by the FSM.
    assign sync_s = sync_ff[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_ff <= '0;
            state   <= STABLE;
            count   <= '0;
            level   <= 1'b0;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], sw};
            state   <= state_nxt;
            count   <= count_nxt;
            level   <= level_nxt;
        end
    end

    // Debounce stage: a new level must mismatch the current output on
    // DEBOUNCE_CYCLES consecutive edges; any match in between restarts.
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        level_nxt = level;
        update    = 1'b0;
        case (state)
            STABLE: begin
                if (sync_s != level) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        level_nxt = sync_s;
                        update    = 1'b1;
                    end else begin
                        count_nxt = FIRST_COUNT;
                        state_nxt = COUNTING;
                    end
                end
            end
            COUNTING: begin
                if (sync_s == level) begin
                    count_nxt = '0;
                    state_nxt = STABLE;
                end else if (count == LAST_COUNT) begin
                    level_nxt = sync_s;
                    update    = 1'b1;
                    count_nxt = '0;
                    state_nxt = STABLE;
                end else begin
                    count_nxt = count + 1'b1;
                end
            end
            default: begin
                count_nxt = '0;
                state_nxt = STABLE;
            end
        endcase
    end

endmodule : debounce_bit

// File: rtl/lab_3_input_conditioner.sv
// lab_3_input_conditioner
// Conditions raw slide switches for the 3-input logic block (bit 2 -> a,
// bit 1 -> b, bit 0 -> c). Each bit is synchronised and debounced
// independently; a single strobe marks any cycle in which the output moves.
// Ports:
//   clk          : system clock
//   rst_n        : asynchronous active-low reset, clears all state
//   sw_in        : raw switch levels, asynchronous and bouncy
//   sw_out       : registered debounced levels
//   changed      : one-cycle pulse on the cycle sw_out takes a new value
//   changed_mask : which sw_out bits changed that cycle, zero otherwise
module lab_3_input_conditioner
    import lab_3_pkg::*;
#(
    parameter int WIDTH           = NUM_SW,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw_in,
    output logic [WIDTH-1:0] sw_out,
    output logic             changed,
    output logic [WIDTH-1:0] changed_mask
);

    logic [WIDTH-1:0] update;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce_bit (
            .clk   (clk),
            .rst_n (rst_n),
            .sw    (sw_in[i]),
            .level (sw_out[i]),
            .update(update[i])
        );
    end

    // Strobe stage: update is asserted the cycle before each level flip, so
    // registering it here places mask and strobe on the same edge as sw_out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            changed_mask <= '0;
            changed      <= 1'b0;
        end else begin
            changed_mask <= update;
            changed      <= |update;
        end
    end

endmodule : lab_3_input_conditioner

// File: tb/tb_lab_3_input_conditioner.sv
module tb_lab_3_input_conditioner;

    localparam int W  = 3;
    localparam int SS = 2;
    localparam int DC = 4;
    localparam int HL = SS + DC;
    localparam int LAT = SS + DC;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] sw_in = 3'b111;
    logic [W-1:0] sw_out;
    logic         changed;
    logic [W-1:0] changed_mask;

    always #5 clk = ~clk;

    lab_3_input_conditioner #(
        .WIDTH          (W),
        .SYNC_STAGES    (SS),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sw_in       (sw_in),
        .sw_out      (sw_out),
        .changed     (changed),
        .changed_mask(changed_mask)
    );

    typedef struct packed {
        logic [W-1:0] out;
        logic         chg;
        logic [W-1:0] mask;
    } obs_t;

    typedef struct {
        logic [W-1:0] sw;
        int           hold;
        logic [W-1:0] exp_mask;
    } vec_t;

    obs_t         sb_q[$];
    logic [W-1:0] sh[HL];
    logic [W-1:0] m_out = '0;
    int           n_vec = 0;
    int           n_err = 0;
    int           cyc = 0;

    // Reference: a bit flips once the last DC synchronised samples all
    // disagree with the current output (sample history window model).
    function automatic void model_step();
        obs_t         e;
        logic [W-1:0] upd;
        logic         all_diff;
        e = '0;
        if (!rst_n) begin
            for (int j = 0; j < HL; j++) sh[j] = '0;
            m_out = '0;
        end else begin
            for (int j = HL - 1; j > 0; j--) sh[j] = sh[j-1];
            sh[0] = sw_in;
            upd = '0;
            for (int b = 0; b < W; b++) begin
                all_diff = 1'b1;
                for (int k = 0; k < DC; k++)
                    if (sh[SS+k][b] == m_out[b]) all_diff = 1'b0;
                upd[b] = all_diff;
            end
            m_out  = m_out ^ upd;
            e.out  = m_out;
            e.chg  = |upd;
            e.mask = upd;
        end
        sb_q.push_back(e);
    endfunction

    initial begin
        for (int j = 0; j < HL; j++) sh[j] = '0;
    end

    // Scoreboard monitor: compare every cycle on the falling edge.
    initial begin
        obs_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_vec++;
                if (sw_out !== e.out || changed !== e.chg || changed_mask !== e.mask) begin
                    n_err++;
                    $display("FAIL sb cycle %0d: got out=%b chg=%b mask=%b, want out=%b chg=%b mask=%b",
                             cyc, sw_out, changed, changed_mask, e.out, e.chg, e.mask);
                end
            end
        end
    end

    initial begin
        #100us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Advance n rising edges; return just after the following falling edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            model_step();
        end
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    // Count edges until the strobe appears (bounded), then check latency,
    // level and mask.
    task automatic wait_change(input string name, input logic [W-1:0] exp_out,
                               input logic [W-1:0] exp_mask);
        int lat;
        lat = 0;
        do begin
            tick(1);
            lat++;
        end while (changed !== 1'b1 && lat < 20);
        check({name, "_latency"}, lat, LAT);
        check({name, "_out"}, sw_out, exp_out);
        check({name, "_mask"}, changed_mask, exp_mask);
    endtask

    vec_t         tbl[8];
    logic [W-1:0] prev;
    int           pulses;
    int           lat;

    initial begin
        // Table of all a/b/c combinations; masks are consecutive XORs,
        // starting from the 001 level left by the bounce test.
        prev = 3'b001;
        for (int i = 0; i < 8; i++) begin
            tbl[i].sw       = W'(i);
            tbl[i].hold     = 10;
            tbl[i].exp_mask = W'(i) ^ prev;
            prev            = W'(i);
        end

        // Reset held with switches high
        #2;
        check("reset_out_async", sw_out, 3'b000);
        tick(3);
        check("reset_out", sw_out, 3'b000);
        check("reset_chg", changed, 1'b0);
        rst_n = 1'b1;
        wait_change("reset_release", 3'b111, 3'b111);
        tick(1);
        check("release_strobe_one_cycle", changed, 1'b0);
        tick(2);

        // Clean step 000 -> 010
        sw_in = 3'b000;
        wait_change("to_zero", 3'b000, 3'b111);
        tick(2);
        sw_in = 3'b010;
        wait_change("clean_step", 3'b010, 3'b010);
        tick(1);
        check("clean_step_mask_clear", changed_mask, 3'b000);
        tick(2);

        // Bounce rejection on bit0
        sw_in = 3'b000;
        wait_change("bounce_prep", 3'b000, 3'b010);
        tick(2);
        sw_in = 3'b001;
        tick(2);
        sw_in = 3'b000;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (changed) pulses++;
        end
        check("bounce_no_strobe", pulses, 0);
        check("bounce_out", sw_out, 3'b000);
        sw_in = 3'b001;
        wait_change("bounce_hold", 3'b001, 3'b001);
        tick(4);

        // Every combination in order
        foreach (tbl[i]) begin
            sw_in = tbl[i].sw;
            wait_change($sformatf("combo_%0d", i), tbl[i].sw, tbl[i].exp_mask);
            tick(tbl[i].hold - LAT);
            check($sformatf("combo_%0d_hold", i), sw_out, tbl[i].sw);
        end

        // Independence: bit2 toggles every cycle while bit1 steps up
        sw_in = 3'b000;
        wait_change("indep_prep", 3'b000, 3'b111);
        tick(2);
        lat = 0;
        do begin
            sw_in = {~sw_in[2], 2'b10};
            tick(1);
            lat++;
        end while (changed !== 1'b1 && lat < 20);
        check("indep_latency", lat, LAT);
        check("indep_mask", changed_mask, 3'b010);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            sw_in = {~sw_in[2], 2'b10};
            tick(1);
            if (changed) pulses++;
        end
        check("indep_no_bit2_strobe", pulses, 0);
        check("indep_out", sw_out, 3'b010);
        sw_in = 3'b010;
        tick(8);

        // Reset mid-count
        sw_in = 3'b000;
        wait_change("midrst_prep", 3'b000, 3'b010);
        tick(2);
        sw_in = 3'b001;
        tick(3);
        rst_n = 1'b0;
        #1;
        check("midrst_out_async", sw_out, 3'b000);
        check("midrst_chg_async", changed, 1'b0);
        tick(2);
        rst_n = 1'b1;
        wait_change("midrst_release", 3'b001, 3'b001);
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_lab_3_input_conditioner
